// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
// Contents:
//   seq_state_t  - sequencer state encoding
//   seq_timer_w  - width of the shared down-counter
//   seq_idx_w    - width of the domain index (minimum 1)
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT   = 2'd0,
    WAIT_ACK = 2'd1,
    GAP      = 2'd2,
    DONE     = 2'd3
  } seq_state_t;

  // Bits needed to hold the largest of the three cycle counts.
  function automatic int unsigned seq_timer_w(input int unsigned hold,
                                              input int unsigned gap,
                                              input int unsigned tmo);
    int unsigned m;
    int unsigned w;
    m = hold;
    if (gap > m) m = gap;
    if (tmo > m) m = tmo;
    w = $clog2(m + 1);
    return w;
  endfunction

  function automatic int unsigned seq_idx_w(input int unsigned n);
    int unsigned w;
    w = (n > 1) ? $clog2(n) : 1;
    return w;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and the subsystems it controls.
// Signals:
//   i_sw_rst_req  single-cycle software reset request
//   i_dom_ack     per-domain reset-done level
//   o_dom_rst     per-domain reset, active-high
//   o_busy        sequence in progress
//   o_done        all domains released
//   o_err_mask    sticky per-domain acknowledge-timeout flags
// Modports: master = sequencer side, slave = subsystem/stimulus side.
interface reset_sequencer_if #(
  parameter int unsigned N_DOM = 4
) ();

  logic             i_sw_rst_req;
  logic [N_DOM-1:0] i_dom_ack;
  logic [N_DOM-1:0] o_dom_rst;
  logic             o_busy;
  logic             o_done;
  logic [N_DOM-1:0] o_err_mask;

  modport master (
    input  i_sw_rst_req,
    input  i_dom_ack,
    output o_dom_rst,
    output o_busy,
    output o_done,
    output o_err_mask
  );

  modport slave (
    output i_sw_rst_req,
    output i_dom_ack,
    input  o_dom_rst,
    input  o_busy,
    input  o_done,
    input  o_err_mask
  );

endinterface

// File: rtl/reset_sequencer_seq_timer.sv
// Shared down-counter: loads a value, decrements to zero and stops there.
// Ports:
//   clk, rst   clock, async active-high reset
//   load       load request (priority over counting)
//   load_val   value to load
//   expired    registered flag, high while the count is zero
module seq_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  // expired tracks cnt == 0 one-for-one, but is kept as its own flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      expired <= 1'b1;
    end else if (load) begin
      cnt     <= load_val;
      expired <= (load_val == '0);
    end else if (cnt != '0) begin
      cnt     <= cnt - W'(1);
      expired <= (cnt == W'(1));
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staggered reset release for N_DOM subsystems of one clock domain.
// Holds all domain resets for HOLD_CYC cycles, then releases them in index
// order, waiting for each acknowledge (bounded by ACK_TIMEOUT) and leaving
// GAP_CYC idle cycles between an acknowledge and the next release.
// Ports:
//   clk  clock
//   rst  async active-high reset (deassertion synchronized upstream)
//   bus  reset_sequencer_if.master: sw request, acks in; resets/status out
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned N_DOM       = 4,
  parameter int unsigned HOLD_CYC    = 16,
  parameter int unsigned GAP_CYC     = 8,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  reset_sequencer_if.master bus
);

  localparam int unsigned TW = seq_timer_w(HOLD_CYC, GAP_CYC, ACK_TIMEOUT);
  localparam int unsigned KW = seq_idx_w(N_DOM);

  localparam logic [KW-1:0] K_LAST  = KW'(N_DOM - 1);
  // The hold spends its first edge arming the timer, hence the -2.
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYC - 2);
  localparam logic [TW-1:0] ACK_LD  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  // Parameter legality
  if (N_DOM < 1) begin : g_bad_n_dom
    $error("reset_sequencer: N_DOM must be >= 1");
  end
  if (HOLD_CYC < 2) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYC must be >= 2");
  end
  if (ACK_TIMEOUT < 1) begin : g_bad_tmo
    $error("reset_sequencer: ACK_TIMEOUT must be >= 1");
  end

  seq_state_t       state;
  logic [KW-1:0]    k;
  logic [KW-1:0]    k_nxt;
  logic             armed;
  logic [N_DOM-1:0] dom_rst;
  logic             busy;
  logic             done;
  logic [N_DOM-1:0] err_mask;

  logic             ack_k_c;
  logic             last_c;
  logic             t_expired;
  logic             t_load_c;
  logic [TW-1:0]    t_val_c;

  assign k_nxt   = k + KW'(1);
  assign ack_k_c = bus.i_dom_ack[k];
  assign last_c  = (k == K_LAST);

  // Timer reload on every state entry; the first edge of ASSERT arms it.
  always_comb begin
    t_load_c = 1'b0;
    t_val_c  = '0;
    if (bus.i_sw_rst_req) begin
      t_load_c = 1'b1;
    end else begin
      case (state)
        ASSERT: begin
          if (!armed) begin
            t_load_c = 1'b1;
            t_val_c  = HOLD_LD;
          end else if (t_expired) begin
            t_load_c = 1'b1;
            t_val_c  = ACK_LD;
          end
        end
        WAIT_ACK: begin
          if (ack_k_c || t_expired) begin
            t_load_c = 1'b1;
            if (last_c)            t_val_c = '0;
            else if (GAP_CYC == 0) t_val_c = ACK_LD;
            else                   t_val_c = GAP_LD;
          end
        end
        GAP: begin
          if (t_expired) begin
            t_load_c = 1'b1;
            t_val_c  = ACK_LD;
          end
        end
        default: ;
      endcase
    end
  end

  seq_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load_c),
    .load_val (t_val_c),
    .expired  (t_expired)
  );

  // Sequencer state and registered outputs; sw request beats any ack/timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ASSERT;
      k        <= '0;
      armed    <= 1'b0;
      dom_rst  <= '1;
      busy     <= 1'b1;
      done     <= 1'b0;
      err_mask <= '0;
    end else if (bus.i_sw_rst_req) begin
      state    <= ASSERT;
      k        <= '0;
      armed    <= 1'b0;
      dom_rst  <= '1;
      busy     <= 1'b1;
      done     <= 1'b0;
      err_mask <= '0;
    end else begin
      case (state)
        ASSERT: begin
          if (!armed) begin
            armed <= 1'b1;
          end else if (t_expired) begin
            dom_rst[0] <= 1'b0;
            k          <= '0;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_k_c || t_expired) begin
            if (!ack_k_c) err_mask[k] <= 1'b1;
            if (last_c) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (GAP_CYC == 0) begin
              // No gap: release the next domain on this same edge.
              dom_rst[k_nxt] <= 1'b0;
              k              <= k_nxt;
              state          <= WAIT_ACK;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (t_expired) begin
            dom_rst[k_nxt] <= 1'b0;
            k              <= k_nxt;
            state          <= WAIT_ACK;
          end
        end
        DONE: ;
        default: state <= ASSERT;
      endcase
    end
  end

  assign bus.o_dom_rst  = dom_rst;
  assign bus.o_busy     = busy;
  assign bus.o_done     = done;
  assign bus.o_err_mask = err_mask;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with N_DOM=3, HOLD_CYC=4, GAP_CYC=2,
// ACK_TIMEOUT=10. Edge numbers are counted from the first rising clk after
// the reset (or software request) being examined.
module tb_reset_sequencer;

  localparam int unsigned N_DOM       = 3;
  localparam int unsigned HOLD_CYC    = 4;
  localparam int unsigned GAP_CYC     = 2;
  localparam int unsigned ACK_TIMEOUT = 10;

  logic clk;
  logic rst;
  int   edge_n;
  int   n_chk;
  int   n_err;

  reset_sequencer_if #(.N_DOM(N_DOM)) bus ();

  reset_sequencer #(
    .N_DOM       (N_DOM),
    .HOLD_CYC    (HOLD_CYC),
    .GAP_CYC     (GAP_CYC),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Advance one rising edge and sample 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic tick_to(input int t);
    while (edge_n < t) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".rst"},  32'(bus.o_dom_rst),  32'h7);
    chk({tag, ".busy"}, 32'(bus.o_busy),     32'h1);
    chk({tag, ".done"}, 32'(bus.o_done),     32'h0);
    chk({tag, ".err"},  32'(bus.o_err_mask), 32'h0);
  endtask

  // Software request issued between edges; returns with edge_n = S.
  task automatic sw_pulse();
    bus.i_sw_rst_req = 1'b1;
    bus.i_dom_ack    = '0;
    tick();
    bus.i_sw_rst_req = 1'b0;
  endtask

  // Each ack becomes visible 3 edges after its domain is released.
  task automatic run_prompt(input int b, input string tag);
    tick_to(b + 3);  chk({tag, ".hold"}, 32'(bus.o_dom_rst), 32'h7);
    tick_to(b + 4);  chk({tag, ".rel0"}, 32'(bus.o_dom_rst), 32'h6);
    tick_to(b + 6);  bus.i_dom_ack = 3'b001;
    tick_to(b + 8);  chk({tag, ".gap0"}, 32'(bus.o_dom_rst), 32'h6);
    tick_to(b + 9);  chk({tag, ".rel1"}, 32'(bus.o_dom_rst), 32'h4);
    tick_to(b + 11); bus.i_dom_ack = 3'b011;
    tick_to(b + 13); chk({tag, ".gap1"}, 32'(bus.o_dom_rst), 32'h4);
    tick_to(b + 14); chk({tag, ".rel2"}, 32'(bus.o_dom_rst), 32'h0);
    tick_to(b + 16); bus.i_dom_ack = 3'b111;
    chk({tag, ".done_pre"}, 32'(bus.o_done), 32'h0);
    chk({tag, ".busy_pre"}, 32'(bus.o_busy), 32'h1);
    tick_to(b + 17);
    chk({tag, ".done"}, 32'(bus.o_done),     32'h1);
    chk({tag, ".busy"}, 32'(bus.o_busy),     32'h0);
    chk({tag, ".err"},  32'(bus.o_err_mask), 32'h0);
  endtask

  // Domain 1 never acknowledges.
  task automatic run_timeout(input int b);
    tick_to(b + 4);  chk("tmo.rel0", 32'(bus.o_dom_rst), 32'h6);
    tick_to(b + 6);  bus.i_dom_ack = 3'b001;
    tick_to(b + 9);  chk("tmo.rel1", 32'(bus.o_dom_rst), 32'h4);
    tick_to(b + 18); chk("tmo.err_pre", 32'(bus.o_err_mask), 32'h0);
    tick_to(b + 19); chk("tmo.err", 32'(bus.o_err_mask), 32'h2);
    chk("tmo.rst19", 32'(bus.o_dom_rst), 32'h4);
    tick_to(b + 20); chk("tmo.gap", 32'(bus.o_dom_rst), 32'h4);
    tick_to(b + 21); chk("tmo.rel2", 32'(bus.o_dom_rst), 32'h0);
    tick_to(b + 23); bus.i_dom_ack = 3'b101;
    tick_to(b + 24);
    chk("tmo.done", 32'(bus.o_done),     32'h1);
    chk("tmo.err_keep", 32'(bus.o_err_mask), 32'h2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk  = 0;
    n_err  = 0;
    edge_n = 0;
    rst    = 1'b1;
    bus.i_sw_rst_req = 1'b0;
    bus.i_dom_ack    = '0;

    // Power-up with prompt acks
    tick(); tick();
    chk_reset_vals("por");
    rst    = 1'b0;
    edge_n = 0;
    run_prompt(0, "pu");

    // Software reset in DONE, then a timeout run
    sw_pulse();
    chk("sw1.rst",  32'(bus.o_dom_rst), 32'h7);
    chk("sw1.done", 32'(bus.o_done),    32'h0);
    chk("sw1.busy", 32'(bus.o_busy),    32'h1);
    run_timeout(edge_n);

    // Software reset clears the error mask; sequence replays identically
    sw_pulse();
    chk("sw2.err",  32'(bus.o_err_mask), 32'h0);
    chk("sw2.rst",  32'(bus.o_dom_rst),  32'h7);
    chk("sw2.done", 32'(bus.o_done),     32'h0);
    run_prompt(edge_n, "replay");

    // Request and ack0 seen on the same edge: request wins
    sw_pulse();
    edge_n = 0;
    tick_to(4);  chk("sim.rel0", 32'(bus.o_dom_rst), 32'h6);
    tick_to(6);
    bus.i_dom_ack    = 3'b001;
    bus.i_sw_rst_req = 1'b1;
    tick();
    bus.i_sw_rst_req = 1'b0;
    chk("sim.rst",  32'(bus.o_dom_rst), 32'h7);
    chk("sim.busy", 32'(bus.o_busy),    32'h1);
    tick_to(9);  chk("sim.nogap", 32'(bus.o_dom_rst), 32'h7);
    tick_to(10); chk("sim.hold",  32'(bus.o_dom_rst), 32'h7);
    tick_to(11); chk("sim.rel0b", 32'(bus.o_dom_rst), 32'h6);
    tick_to(13); chk("sim.gap",   32'(bus.o_dom_rst), 32'h6);
    tick_to(14); chk("sim.rel1",  32'(bus.o_dom_rst), 32'h4);

    // Stale and foreign acks held high across reset
    rst = 1'b1;
    bus.i_dom_ack = 3'b111;
    tick(); tick();
    chk_reset_vals("stale.por");
    rst    = 1'b0;
    edge_n = 0;
    tick_to(3);  chk("stale.hold", 32'(bus.o_dom_rst), 32'h7);
    tick_to(4);  chk("stale.rel0", 32'(bus.o_dom_rst), 32'h6);
    tick_to(6);  chk("stale.gap0", 32'(bus.o_dom_rst), 32'h6);
    tick_to(7);  chk("stale.rel1", 32'(bus.o_dom_rst), 32'h4);
    tick_to(9);  chk("stale.gap1", 32'(bus.o_dom_rst), 32'h4);
    tick_to(10); chk("stale.rel2", 32'(bus.o_dom_rst), 32'h0);
    chk("stale.busy", 32'(bus.o_busy), 32'h1);
    tick_to(11); chk("stale.done", 32'(bus.o_done), 32'h1);

    // Domain 0 times out, then async reset lands mid-GAP
    sw_pulse();
    edge_n = 0;
    tick_to(4);  chk("ar.rel0", 32'(bus.o_dom_rst), 32'h6);
    tick_to(13); chk("ar.err_pre", 32'(bus.o_err_mask), 32'h0);
    tick_to(14); chk("ar.err", 32'(bus.o_err_mask), 32'h1);
    tick_to(15); chk("ar.gap", 32'(bus.o_dom_rst), 32'h6);
    rst = 1'b1;
    #2;
    chk_reset_vals("ar.async");
    tick();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Reset sequencer that drives the per-subsystem resets of one clock domain. Reset release is staggered across `N_DOM` subsystems in a fixed order. On power-up or a software reset request it does the following:
- asserts every domain reset and holds them for a minimum width;
- releases the domains one at a time, in index order;
- waits for each domain's reset-done acknowledge before moving on, with a timeout.

It sits directly downstream of the domain's asynchronous reset synchronizer and fans out to subsystem reset inputs.

## Interface
Parameters:
- `N_DOM`, 4: number of sequenced domains; min 1.
- `HOLD_CYC`, 16: cycles all domain resets stay asserted before the first release; min 2.
- `GAP_CYC`, 8: idle cycles between an acknowledge and the next release; 0 allowed, meaning no gap.
- `ACK_TIMEOUT`, 255: maximum cycles to wait for each acknowledge; min 1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high. Deassertion is already synchronized to `clk` upstream.
- `i_sw_rst_req`  in  1  single-cycle software reset request, synchronous to `clk`.
- `i_dom_ack`  in  N_DOM  per-domain reset-done level, already synchronous to `clk`.
- `o_dom_rst`  out  N_DOM  per-domain reset, active-high, registered.
- `o_busy`  out  1  sequence in progress.
- `o_done`  out  1  all domains released.
- `o_err_mask`  out  N_DOM  sticky per-domain acknowledge-timeout flags.

## Operation
Reset values:
- `o_dom_rst` = all ones; `o_busy` = 1; `o_done` = 0; `o_err_mask` = 0.
- State = ASSERT; timer = 0; domain index k = 0.

States:
- **ASSERT**
  - All `o_dom_rst` are high; the timer counts.
  - After HOLD_CYC cycles: clear `o_dom_rst[0]` and go to WAIT_ACK with k = 0.
- **WAIT_ACK**
  - Samples `i_dom_ack[k]` and counts the timer.
  - On ack = 1, or when the timeout expires:
    - if k = N_DOM-1, go to DONE;
    - otherwise, go to GAP.
  - On timeout, also set `o_err_mask[k]`.
- **GAP**
  - Counts GAP_CYC cycles, then clears `o_dom_rst[k+1]`, increments k and goes to WAIT_ACK.
  - When GAP_CYC = 0, the release happens on the same edge that leaves WAIT_ACK; the GAP state is bypassed.
- **DONE**
  - `o_done` = 1, `o_busy` = 0. Held indefinitely.

Software reset:
- `i_sw_rst_req` = 1 in any state: on the next edge, all `o_dom_rst` go to 1, `o_err_mask` clears, k and the timer clear, and state becomes ASSERT.
- A request during ASSERT restarts the hold count.
- A request takes priority over a simultaneous ack or timeout.

Other rules:
- A released domain is never re-asserted except by `rst` or `i_sw_rst_req`.
- `i_dom_ack` bits for domains other than k are ignored.
- Asserting `rst` mid-sequence forces the reset values immediately (asynchronously).
- The timer is a single shared down-counter, `$clog2(max(HOLD_CYC, GAP_CYC, ACK_TIMEOUT)+1)` bits wide. It is reloaded on every state entry and never wraps.
- The domain index is `$clog2(N_DOM)` bits wide, minimum 1.

## Timing
Edges are numbered from edge 1, the first rising `clk` after `rst` deasserts.
- `o_dom_rst[0]` falls at edge HOLD_CYC.
- WAIT_ACK entered at edge R:
  - ack is sampled from edge R+1 onward;
  - a timeout is declared at edge R+ACK_TIMEOUT if ack was low on every sample.
- After ack (or timeout) is recognised at edge E:
  - `o_dom_rst[k+1]` falls at edge E+GAP_CYC;
  - for the last domain, `o_done` rises (and `o_busy` falls) at edge E.
- `i_sw_rst_req` sampled high at edge S: `o_dom_rst` = all ones after edge S, and the new hold completes at edge S+HOLD_CYC.
- All outputs are registered, with no combinational path from any input to any output.

## Structure
- Package `reset_seq_pkg` holds:
  - the `seq_state_t` enum: ASSERT, WAIT_ACK, GAP, DONE;
  - the `seq_timer_w` width function.
- One sub-module, `seq_timer`:
  - inputs: load, load value;
  - behaviour: decrements to zero and stops;
  - output: a registered `expired` flag.
- Parameter legality is checked by elaboration-time assertions.

## Test plan
All scenarios use N_DOM=3, HOLD_CYC=4, GAP_CYC=2, ACK_TIMEOUT=10.
- **Power-up, prompt acks.** Release `rst`; raise each `i_dom_ack[k]` 3 cycles after `o_dom_rst[k]` falls.
  - `o_dom_rst`: 111 → 110 at edge 4 → 100 at edge 9 → 000 at edge 14.
  - `o_done` = 1 at edge 17; `o_err_mask` = 000.
- **Timeout.** Domain 1 never acks.
  - `o_err_mask` = 010 exactly 10 edges after `o_dom_rst[1]` falls.
  - `o_dom_rst[2]` falls 2 edges later; `o_done` still reaches 1.
- **Software reset while in DONE.** Pulse `i_sw_rst_req`.
  - `o_dom_rst` = 111 and `o_done` = 0 on the next edge.
  - Full sequence replays with the same cycle offsets; `o_err_mask` is cleared.
- **Simultaneous events.** Pulse `i_sw_rst_req` in the same cycle as `i_dom_ack[0]` rises.
  - Request wins: state = ASSERT, no GAP entered, `o_dom_rst` = 111.
- **Asynchronous reset mid-sequence.** Assert `rst` between clock edges during GAP.
  - Outputs return to their reset values before the next edge.
- **Stale and foreign acks.** Hold `i_dom_ack` = 111 from time 0.
  - Each release still waits at least 1 cycle in WAIT_ACK.
  - Releases occur at edges 4, 7 and 10; acks for non-current domains never advance the sequence.
